// File: rtl/mcpu_itlb.sv
// Instruction TLB for the fetch stage: small fully-associative translation cache
// backed by a two-level hardware page-table walker on a single memory read port.
module mcpu_itlb #(
  parameter int ENTRIES = 8
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst,
  input  logic        ft2itlb_valid,
  input  logic [19:0] ft2itlb_virtpage,
  output logic        ft2itlb_ready,
  output logic [19:0] ft2itlb_physpage,
  output logic        ft2itlb_pagefault,
  input  logic        paging_en,
  input  logic [19:0] ptbr,
  input  logic        itlb_flush,
  output logic        itlb2mem_valid,
  output logic [31:0] itlb2mem_addr,
  input  logic        mem2itlb_ready,
  input  logic [31:0] mem2itlb_data
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, WALK1, WALK2, RESP} state_t;

  state_t             state_q, state_d;
  logic [19:0]        vpn_q, vpn_d;
  logic               ready_d, fault_d, mem_valid_d;
  logic [19:0]        phys_d;
  logic [31:0]        addr_d;
  logic               install;
  logic               walk_flushed_q;

  logic [ENTRIES-1:0] valid_q;
  logic [19:0]        tag_q  [ENTRIES];
  logic [19:0]        data_q [ENTRIES];
  logic [IDX_W-1:0]   rr_q;

  logic               hit;
  logic [19:0]        hit_data;

  // PDE/PTE flag bits other than present carry no meaning for instruction fetch
  logic               unused_pte_bits;
  assign unused_pte_bits = ^mem2itlb_data[11:1];

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == ft2itlb_virtpage)) begin
        hit      = 1'b1;
        hit_data = data_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    vpn_d       = vpn_q;
    ready_d     = 1'b0;
    phys_d      = ft2itlb_physpage;
    fault_d     = ft2itlb_pagefault;
    mem_valid_d = itlb2mem_valid;
    addr_d      = itlb2mem_addr;
    install     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ft2itlb_valid) begin
          vpn_d = ft2itlb_virtpage;
          if (!paging_en) begin
            phys_d  = ft2itlb_virtpage;
            fault_d = 1'b0;
            ready_d = 1'b1;
            state_d = RESP;
          end else if (hit) begin
            phys_d  = hit_data;
            fault_d = 1'b0;
            ready_d = 1'b1;
            state_d = RESP;
          end else begin
            mem_valid_d = 1'b1;
            addr_d      = {ptbr, ft2itlb_virtpage[19:10], 2'b00};
            state_d     = WALK1;
          end
        end
      end
      WALK1: begin
        if (mem2itlb_ready) begin
          if (!mem2itlb_data[0]) begin
            mem_valid_d = 1'b0;
            phys_d      = '0;
            fault_d     = 1'b1;
            ready_d     = 1'b1;
            state_d     = RESP;
          end else begin
            mem_valid_d = 1'b1;
            addr_d      = {mem2itlb_data[31:12], vpn_q[9:0], 2'b00};
            state_d     = WALK2;
          end
        end
      end
      WALK2: begin
        if (mem2itlb_ready) begin
          mem_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = RESP;
          if (!mem2itlb_data[0]) begin
            phys_d  = '0;
            fault_d = 1'b1;
          end else begin
            phys_d  = mem2itlb_data[31:12];
            fault_d = 1'b0;
            // A flush seen anywhere in this walk means the result may be stale
            install = !walk_flushed_q && !itlb_flush;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_q           <= IDLE;
      vpn_q             <= '0;
      ft2itlb_ready     <= 1'b0;
      ft2itlb_physpage  <= '0;
      ft2itlb_pagefault <= 1'b0;
      itlb2mem_valid    <= 1'b0;
      itlb2mem_addr     <= '0;
      walk_flushed_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      vpn_q             <= vpn_d;
      ft2itlb_ready     <= ready_d;
      ft2itlb_physpage  <= phys_d;
      ft2itlb_pagefault <= fault_d;
      itlb2mem_valid    <= mem_valid_d;
      itlb2mem_addr     <= addr_d;
      if (state_q == IDLE)
        walk_flushed_q <= 1'b0;
      else if (itlb_flush)
        walk_flushed_q <= 1'b1;
    end
  end

  // Round-robin replacement; pointer wraps naturally since ENTRIES is a power of two
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      if (itlb_flush)
        valid_q <= '0;
      else if (install)
        valid_q[rr_q] <= 1'b1;
      if (install) begin
        tag_q[rr_q]  <= vpn_q;
        data_q[rr_q] <= mem2itlb_data[31:12];
        rr_q         <= rr_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mcpu_itlb.sv
// Scoreboard bench for mcpu_itlb: a driver queues expected translations, a
// monitor checks each ready pulse, and a memory model serves the page walker.
module tb_mcpu_itlb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ft2itlb_valid;
  logic [19:0] ft2itlb_virtpage;
  logic        ft2itlb_ready;
  logic [19:0] ft2itlb_physpage;
  logic        ft2itlb_pagefault;
  logic        paging_en;
  logic [19:0] ptbr;
  logic        itlb_flush;
  logic        itlb2mem_valid;
  logic [31:0] itlb2mem_addr;
  logic        mem2itlb_ready;
  logic [31:0] mem2itlb_data;

  logic        stim_flush, model_flush, model_ready, stray_ready;
  logic [31:0] model_data;
  assign itlb_flush     = stim_flush | model_flush;
  assign mem2itlb_ready = model_ready | stray_ready;
  assign mem2itlb_data  = model_data;

  mcpu_itlb #(.ENTRIES(8)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst   (rst),
    .ft2itlb_valid     (ft2itlb_valid),
    .ft2itlb_virtpage  (ft2itlb_virtpage),
    .ft2itlb_ready     (ft2itlb_ready),
    .ft2itlb_physpage  (ft2itlb_physpage),
    .ft2itlb_pagefault (ft2itlb_pagefault),
    .paging_en         (paging_en),
    .ptbr              (ptbr),
    .itlb_flush        (itlb_flush),
    .itlb2mem_valid    (itlb2mem_valid),
    .itlb2mem_addr     (itlb2mem_addr),
    .mem2itlb_ready    (mem2itlb_ready),
    .mem2itlb_data     (mem2itlb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  // lat == 1: ready one cycle after issue; lat == 0: ready one cycle after last memory response
  typedef struct {
    logic [19:0] phys;
    logic        fault;
    int          lat;
    int          reads;
    int          issue_cyc;
    int          start_reads;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem_img [logic [31:0]];
  logic [31:0] addr_log[$];
  int          reads_total  = 0;
  int          last_mem_cyc = 0;
  logic        mem_enable   = 1'b1;
  logic        arm_flush    = 1'b0;
  logic        flush_next   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [19:0] vpn, input logic pen, input logic flush_with,
                               input logic [19:0] phys, input logic fault, input int lat,
                               input int reads);
    exp_t e;
    bit   got;
    @(negedge clk);
    e.phys        = phys;
    e.fault       = fault;
    e.lat         = lat;
    e.reads       = reads;
    e.issue_cyc   = cyc;
    e.start_reads = reads_total;
    sb.push_back(e);
    ft2itlb_virtpage = vpn;
    paging_en        = pen;
    ft2itlb_valid    = 1'b1;
    stim_flush       = flush_with;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      stim_flush = 1'b0;
      if (ft2itlb_ready) begin
        got = 1'b1;
        break;
      end
    end
    ft2itlb_valid = 1'b0;
    if (!got) begin
      tests++;
      failed++;
      $display("[TB] FAIL timeout vpn=0x%0h: got no ready, expected ready within 100 cycles", vpn);
      if (sb.size() > 0) e = sb.pop_back();
    end
  endtask

  // Monitor: every ready pulse is matched against the oldest expectation
  exp_t mon_e;
  always @(negedge clk) begin
    if (ft2itlb_ready) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_ready: got ready=1, expected no response pending");
      end else begin
        mon_e = sb.pop_front();
        checkOutput("physpage", {12'h0, ft2itlb_physpage}, {12'h0, mon_e.phys});
        checkOutput("pagefault", {31'h0, ft2itlb_pagefault}, {31'h0, mon_e.fault});
        checkOutput("mem_reads", reads_total - mon_e.start_reads, mon_e.reads);
        if (mon_e.lat == 1)
          checkOutput("latency_hit", cyc - mon_e.issue_cyc, 1);
        else
          checkOutput("latency_walk", cyc - last_mem_cyc, 1);
      end
    end
  end

  // Memory model: answers each walker request after two cycles of latency
  initial begin
    model_ready = 1'b0;
    model_flush = 1'b0;
    model_data  = '0;
    forever begin
      @(negedge clk);
      model_ready = 1'b0;
      model_flush = 1'b0;
      if (flush_next) begin
        model_flush = 1'b1;
        flush_next  = 1'b0;
      end
      if (mem_enable && itlb2mem_valid && !rst) begin
        repeat (2) begin
          @(negedge clk);
          model_flush = 1'b0;
        end
        model_ready = 1'b1;
        model_data  = mem_img.exists(itlb2mem_addr) ? mem_img[itlb2mem_addr] : 32'h0;
        addr_log.push_back(itlb2mem_addr);
        reads_total++;
        last_mem_cyc = cyc;
        if (arm_flush) begin
          flush_next = 1'b1;
          arm_flush  = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    ft2itlb_valid    = 1'b0;
    ft2itlb_virtpage = '0;
    paging_en        = 1'b0;
    ptbr             = 20'h00100;
    stim_flush       = 1'b0;
    stray_ready      = 1'b0;

    mem_img[32'h0010_0004] = 32'h0020_0001;
    mem_img[32'h0020_0004] = 32'hABCD_E001;
    for (int k = 0; k < 9; k++)
      mem_img[32'h0020_0000 + ((32'h10 + k) << 2)] = {20'h50010 + 20'(k), 12'h001};

    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'h0, ft2itlb_ready}, 32'h0);
    checkOutput("rst_physpage", {12'h0, ft2itlb_physpage}, 32'h0);
    checkOutput("rst_fault", {31'h0, ft2itlb_pagefault}, 32'h0);
    checkOutput("rst_memvalid", {31'h0, itlb2mem_valid}, 32'h0);
    checkOutput("rst_memaddr", itlb2mem_addr, 32'h0);
    rst = 1'b0;

    $display("[TB] T1 identity map");
    applyStimulus(20'h12345, 1'b0, 1'b0, 20'h12345, 1'b0, 1, 0);

    $display("[TB] T2 two-level walk then hit");
    addr_log.delete();
    applyStimulus(20'h00401, 1'b1, 1'b0, 20'hABCDE, 1'b0, 0, 2);
    checkOutput("t2_nreads", addr_log.size(), 2);
    checkOutput("t2_pde_addr", (addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF, 32'h0010_0004);
    checkOutput("t2_pte_addr", (addr_log.size() > 1) ? addr_log[1] : 32'hFFFF_FFFF, 32'h0020_0004);
    applyStimulus(20'h00401, 1'b1, 1'b0, 20'hABCDE, 1'b0, 1, 0);

    $display("[TB] T3 non-present PDE");
    applyStimulus(20'h00800, 1'b1, 1'b0, 20'h00000, 1'b1, 0, 1);
    applyStimulus(20'h00800, 1'b1, 1'b0, 20'h00000, 1'b1, 0, 1);

    $display("[TB] T4 round-robin wrap");
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 9; k++)
      applyStimulus(20'h00410 + 20'(k), 1'b1, 1'b0, 20'h50010 + 20'(k), 1'b0, 0, 2);
    applyStimulus(20'h00411, 1'b1, 1'b0, 20'h50011, 1'b0, 1, 0);
    applyStimulus(20'h00418, 1'b1, 1'b0, 20'h50018, 1'b0, 1, 0);
    applyStimulus(20'h00410, 1'b1, 1'b0, 20'h50010, 1'b0, 0, 2);

    $display("[TB] T5 flushes");
    arm_flush = 1'b1;
    applyStimulus(20'h00401, 1'b1, 1'b0, 20'hABCDE, 1'b0, 0, 2);
    applyStimulus(20'h00401, 1'b1, 1'b0, 20'hABCDE, 1'b0, 0, 2);
    applyStimulus(20'h00412, 1'b1, 1'b0, 20'h50012, 1'b0, 0, 2);
    applyStimulus(20'h00401, 1'b1, 1'b0, 20'hABCDE, 1'b0, 1, 0);
    @(negedge clk) stim_flush = 1'b1;
    @(negedge clk) stim_flush = 1'b0;
    applyStimulus(20'h00401, 1'b1, 1'b0, 20'hABCDE, 1'b0, 0, 2);
    applyStimulus(20'h00412, 1'b1, 1'b0, 20'h50012, 1'b0, 0, 2);
    applyStimulus(20'h00412, 1'b1, 1'b1, 20'h50012, 1'b0, 1, 0);
    applyStimulus(20'h00412, 1'b1, 1'b0, 20'h50012, 1'b0, 0, 2);

    $display("[TB] T6 reset during walk");
    mem_enable = 1'b0;
    @(negedge clk);
    ft2itlb_virtpage = 20'h00700;
    paging_en        = 1'b1;
    ft2itlb_valid    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (itlb2mem_valid) break;
    end
    checkOutput("t6_walk_started", {31'h0, itlb2mem_valid}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    ft2itlb_valid = 1'b0;
    checkOutput("t6_memvalid", {31'h0, itlb2mem_valid}, 32'h0);
    checkOutput("t6_ready", {31'h0, ft2itlb_ready}, 32'h0);
    @(negedge clk) stray_ready = 1'b1;
    @(negedge clk) stray_ready = 1'b0;
    checkOutput("t6_stray_ready", {31'h0, ft2itlb_ready}, 32'h0);
    checkOutput("t6_stray_memvalid", {31'h0, itlb2mem_valid}, 32'h0);
    mem_enable = 1'b1;
    applyStimulus(20'h00412, 1'b1, 1'b0, 20'h50012, 1'b0, 0, 2);
    applyStimulus(20'h0ABCD, 1'b0, 1'b0, 20'h0ABCD, 1'b0, 1, 0);

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
